// File: rtl/centroid_area_tracker.sv
`default_nettype none
// ============================================================================
// Module      : centroid_area_tracker
// Description : Accumulates the column sum, the row sum and the count of
//               masked pixels over one frame. At frame end it divides both
//               sums by the count and reports the centroid and the area.
//               Two restoring dividers run in parallel and produce one
//               quotient bit per cycle.
// Ports       : clk_in          - sole clock, rising edge
//               rst_in          - synchronous, active-low reset
//               hcount_in       - pixel column
//               vcount_in       - pixel row
//               mask_in         - pixel selected for tracking
//               pixel_valid_in  - hcount/vcount/mask qualified this cycle
//               frame_done_in   - single-cycle end-of-frame pulse
//               x_out/y_out     - centroid column/row (floored quotients)
//               area_out        - masked-pixel count of the reported frame
//               valid_out       - one-cycle pulse qualifying the results
//               busy_out        - division in progress
// Revision    : 1.0 - initial release
// ============================================================================
module centroid_area_tracker #(
    parameter int HRES     = 320,
    parameter int VRES     = 180,
    parameter int MIN_AREA = 16,
    localparam int HWIDTH  = $clog2(HRES),
    localparam int VWIDTH  = $clog2(VRES),
    localparam int AWIDTH  = $clog2(HRES * VRES),
    localparam int SUMW    = HWIDTH + AWIDTH
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [HWIDTH-1:0] hcount_in,
    input  logic [VWIDTH-1:0] vcount_in,
    input  logic              mask_in,
    input  logic              pixel_valid_in,
    input  logic              frame_done_in,
    output logic [HWIDTH-1:0] x_out,
    output logic [VWIDTH-1:0] y_out,
    output logic [AWIDTH-1:0] area_out,
    output logic              valid_out,
    output logic              busy_out
);

    localparam int STEPW = $clog2(SUMW);

    localparam logic [HWIDTH:0]   c_hres_lim = (HWIDTH + 1)'(HRES);
    localparam logic [VWIDTH:0]   c_vres_lim = (VWIDTH + 1)'(VRES);
    localparam logic [AWIDTH-1:0] c_min_area = AWIDTH'(MIN_AREA);
    localparam logic [STEPW-1:0]  c_last_step = STEPW'(SUMW - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            r_state;

    // Running per-frame accumulators
    logic [SUMW-1:0]   r_sum_x;
    logic [SUMW-1:0]   r_sum_y;
    logic [AWIDTH-1:0] r_count;

    // Divider state: r_q* starts as the dividend and is shifted left, the
    // quotient bits entering at the bottom; after SUMW steps it is the quotient.
    logic [SUMW-1:0]   r_qx;
    logic [SUMW-1:0]   r_qy;
    logic [AWIDTH-1:0] r_rx;
    logic [AWIDTH-1:0] r_ry;
    logic [AWIDTH-1:0] r_div;
    logic [STEPW-1:0]  r_step;

    logic [HWIDTH-1:0] r_x;
    logic [VWIDTH-1:0] r_y;
    logic [AWIDTH-1:0] r_area;
    logic              r_valid;
    logic              r_busy;

    logic              w_pix_ok;
    logic [SUMW-1:0]   w_sum_x_nxt;
    logic [SUMW-1:0]   w_sum_y_nxt;
    logic [AWIDTH-1:0] w_count_nxt;
    logic [AWIDTH:0]   w_stx;
    logic [AWIDTH:0]   w_sty;

    // One restoring-division step. Returns {quotient_bit, new_remainder}.
    // The remainder is always below the divisor, so the shifted value fits in
    // AWIDTH+1 bits and the difference fits back into AWIDTH bits.
    function automatic logic [AWIDTH:0] f_div_step(
        input logic [AWIDTH-1:0] rem,
        input logic              bit_in,
        input logic [AWIDTH-1:0] dvs
    );
        logic [AWIDTH:0] sh;
        sh = {rem, bit_in};
        if (sh >= {1'b0, dvs}) begin
            return {1'b1, sh[AWIDTH-1:0] - dvs};
        end
        return {1'b0, sh[AWIDTH-1:0]};
    endfunction

    assign w_pix_ok = pixel_valid_in & mask_in
                    & ({1'b0, hcount_in} < c_hres_lim)
                    & ({1'b0, vcount_in} < c_vres_lim);

    // Next accumulator values include this cycle's pixel, so the snapshot
    // taken on a frame_done cycle contains the pixel presented with it.
    assign w_sum_x_nxt = r_sum_x + (w_pix_ok ? SUMW'(hcount_in) : '0);
    assign w_sum_y_nxt = r_sum_y + (w_pix_ok ? SUMW'(vcount_in) : '0);
    assign w_count_nxt = (w_pix_ok && (r_count != '1)) ? r_count + AWIDTH'(1)
                                                       : r_count;

    assign w_stx = f_div_step(r_rx, r_qx[SUMW-1], r_div);
    assign w_sty = f_div_step(r_ry, r_qy[SUMW-1], r_div);

    // Accumulators restart from zero after every frame_done, whether or not
    // the frame is reported, so the next frame never inherits stale pixels.
    always_ff @(posedge clk_in) begin
        if (!rst_in || frame_done_in) begin
            r_sum_x <= '0;
            r_sum_y <= '0;
            r_count <= '0;
        end else begin
            r_sum_x <= w_sum_x_nxt;
            r_sum_y <= w_sum_y_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= S_IDLE;
            r_qx    <= '0;
            r_qy    <= '0;
            r_rx    <= '0;
            r_ry    <= '0;
            r_div   <= '0;
            r_step  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_area  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // frame_done outside IDLE is ignored here: its frame is dropped.
                    if (frame_done_in && (w_count_nxt >= c_min_area)) begin
                        r_qx    <= w_sum_x_nxt;
                        r_qy    <= w_sum_y_nxt;
                        r_div   <= w_count_nxt;
                        r_rx    <= '0;
                        r_ry    <= '0;
                        r_step  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    r_rx   <= w_stx[AWIDTH-1:0];
                    r_ry   <= w_sty[AWIDTH-1:0];
                    r_qx   <= {r_qx[SUMW-2:0], w_stx[AWIDTH]};
                    r_qy   <= {r_qy[SUMW-2:0], w_sty[AWIDTH]};
                    r_step <= r_step + STEPW'(1);
                    if (r_step == c_last_step) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_x     <= r_qx[HWIDTH-1:0];
                    r_y     <= r_qy[VWIDTH-1:0];
                    r_area  <= r_div;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign x_out     = r_x;
    assign y_out     = r_y;
    assign area_out  = r_area;
    assign valid_out = r_valid;
    assign busy_out  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_centroid_area_tracker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_centroid_area_tracker
// Description : Self-checking bench for centroid_area_tracker. A frame-level
//               reference model (running sums, integer division, acceptance
//               window after each reported frame_done) predicts outputs for
//               every cycle. Directed frames plus randomized frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_centroid_area_tracker;

    localparam int HRES     = 320;
    localparam int VRES     = 180;
    localparam int MIN_AREA = 16;
    localparam int HW       = $clog2(HRES);
    localparam int VW       = $clog2(VRES);
    localparam int AW       = $clog2(HRES * VRES);
    localparam int SW       = HW + AW;
    localparam int LAT      = SW + 1;   // edges from accepting edge to valid_out edge

    logic          clk = 1'b0;
    logic          rst_n;
    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic          msk;
    logic          pv;
    logic          fd;
    logic [HW-1:0] x_out;
    logic [VW-1:0] y_out;
    logic [AW-1:0] area_out;
    logic          valid_out;
    logic          busy_out;

    always #5 clk = ~clk;

    centroid_area_tracker #(
        .HRES     (HRES),
        .VRES     (VRES),
        .MIN_AREA (MIN_AREA)
    ) u_dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .hcount_in      (hc),
        .vcount_in      (vc),
        .mask_in        (msk),
        .pixel_valid_in (pv),
        .frame_done_in  (fd),
        .x_out          (x_out),
        .y_out          (y_out),
        .area_out       (area_out),
        .valid_out      (valid_out),
        .busy_out       (busy_out)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;     // number of rising edges so far
    int n_valid = 0;   // valid_out pulses observed

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    longint m_sx = 0, m_sy = 0;
    int     m_cnt = 0;
    bit     p_act = 1'b0;
    int     p_edge = 0;
    int     p_x = 0, p_y = 0, p_a = 0;
    int     e_x = 0, e_y = 0, e_a = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One cycle: check the state after the last edge, then drive inputs for
    // the next edge and advance the model for that edge.
    task automatic step(input int h, input int v, input bit m, input bit pvi,
                        input bit fdi, input bit rstn);
        bit exp_busy;
        @(negedge clk);
        if (valid_out === 1'b1) n_valid++;
        if (p_act && cyc == p_edge + LAT) begin
            e_x = p_x; e_y = p_y; e_a = p_a;
            p_act = 1'b0;
            chk("valid_out", valid_out, 1);
        end else begin
            chk("valid_out", valid_out, 0);
        end
        exp_busy = p_act && (cyc >= p_edge) && (cyc < p_edge + LAT);
        chk("busy_out", busy_out, exp_busy);
        chk("x_out", x_out, e_x);
        chk("y_out", y_out, e_y);
        chk("area_out", area_out, e_a);

        hc    = h[HW-1:0];
        vc    = v[VW-1:0];
        msk   = m;
        pv    = pvi;
        fd    = fdi;
        rst_n = rstn;

        if (!rstn) begin
            m_sx = 0; m_sy = 0; m_cnt = 0;
            p_act = 1'b0;
            e_x = 0; e_y = 0; e_a = 0;
        end else begin
            if (pvi && m && h < HRES && v < VRES) begin
                m_sx += h; m_sy += v; m_cnt++;
            end
            if (fdi) begin
                if (!p_act && m_cnt >= MIN_AREA) begin
                    p_act  = 1'b1;
                    p_edge = cyc + 1;
                    p_x    = int'(m_sx / m_cnt);
                    p_y    = int'(m_sy / m_cnt);
                    p_a    = m_cnt;
                end
                m_sx = 0; m_sy = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic frame_end();
        step(0, 0, 0, 0, 1, 1);
    endtask

    // Rectangle of masked pixels with random unqualified gap cycles.
    task automatic block(input int x0, input int y0, input int w, input int h);
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                if ($urandom_range(0, 3) == 0)
                    step(int'($urandom_range(0, 319)), int'($urandom_range(0, 179)), 1, 0, 0, 1);
                step(x0 + xx, y0 + yy, 1, 1, 0, 1);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        rst_n = 1'b0; hc = '0; vc = '0; msk = 1'b0; pv = 1'b0; fd = 1'b0;
        repeat (2) @(posedge clk);
        repeat (3) step(5, 5, 1, 1, 1, 0);      // reset dominates stimulus
        idle(2);

        // 4x4 block centred between 101 and 102 -> floor gives 101/51
        nv = n_valid;
        block(100, 50, 4, 4);
        frame_end();
        idle(30);
        chk("blk_x", x_out, 101);
        chk("blk_y", y_out, 51);
        chk("blk_area", area_out, 16);
        chk("blk_pulses", n_valid - nv, 1);

        // 4x5 block, frame_done on the last pixel (pixel belongs to this frame)
        block(10, 0, 4, 4);
        for (int xx = 0; xx < 3; xx++) step(10 + xx, 4, 1, 1, 0, 1);
        step(13, 4, 1, 1, 1, 1);
        idle(30);
        chk("flr_x", x_out, 11);
        chk("flr_y", y_out, 2);
        chk("flr_area", area_out, 20);

        // Below MIN_AREA: single pixel, then empty frame
        nv = n_valid;
        step(77, 77, 1, 1, 0, 1);
        frame_end();
        idle(30);
        frame_end();
        idle(30);
        chk("small_pulses", n_valid - nv, 0);
        chk("small_x", x_out, 11);
        chk("small_area", area_out, 20);

        // Frame B ends while A divides; B discarded, C reports only its own
        nv = n_valid;
        block(100, 50, 4, 4);
        frame_end();
        for (int i = 0; i < 15; i++) step(0, i, 1, 1, 0, 1);
        step(0, 15, 1, 1, 1, 1);
        idle(30);
        chk("ovl_x", x_out, 101);
        chk("ovl_pulses", n_valid - nv, 1);
        block(20, 30, 4, 4);
        frame_end();
        idle(30);
        chk("c_x", x_out, 21);
        chk("c_y", y_out, 31);
        chk("c_area", area_out, 16);

        // Reset during the division
        nv = n_valid;
        block(50, 60, 4, 4);
        frame_end();
        repeat (3) step(7, 7, 1, 1, 0, 1);
        idle(2);
        step(0, 0, 0, 0, 0, 0);
        idle(30);
        chk("rst_pulses", n_valid - nv, 0);
        chk("rst_x", x_out, 0);
        chk("rst_area", area_out, 0);
        chk("rst_busy", busy_out, 0);
        repeat (16) step(200, 100, 1, 1, 0, 1);
        frame_end();
        idle(30);
        chk("post_x", x_out, 200);
        chk("post_y", y_out, 100);
        chk("post_area", area_out, 16);

        // Out-of-range pixels interleaved with a valid block
        for (int yy = 0; yy < 4; yy++) begin
            for (int xx = 0; xx < 4; xx++) begin
                step(HRES, 120 + yy, 1, 1, 0, 1);
                step(150 + xx, VRES, 1, 1, 0, 1);
                step(150 + xx, 120 + yy, 1, 1, 0, 1);
            end
        end
        frame_end();
        idle(30);
        chk("oor_x", x_out, 151);
        chk("oor_y", y_out, 121);
        chk("oor_area", area_out, 16);

        // Randomized frames; short gaps make some frame_done land while busy
        for (int f = 0; f < 16; f++) begin
            int np, cx, cy;
            np = int'($urandom_range(0, 40));
            cx = int'($urandom_range(0, 300));
            cy = int'($urandom_range(0, 170));
            for (int i = 0; i < np; i++) begin
                int h, v;
                if ($urandom_range(0, 9) == 0) begin
                    h = int'($urandom_range(0, 330));
                    v = int'($urandom_range(0, 190));
                end else begin
                    h = cx + int'($urandom_range(0, 20));
                    v = cy + int'($urandom_range(0, 10));
                end
                step(h, v, $urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0,
                     i == np - 1 && $urandom_range(0, 1) == 1, 1);
            end
            frame_end();
            idle(int'($urandom_range(0, 35)));
        end
        idle(30);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
